// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit single-port memory between instruction fetch and load/store.
// Optional build macro: MEM_ARB_STATS_EN adds grant and conflict counters.
module mem_port_arbiter #(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic [31:0] if_instr,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic [63:0] d_rdata,
   output logic        d_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        stall
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_if_grants,
   output logic [31:0] stat_d_grants,
   output logic [31:0] stat_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [2:0]  r_cnt;
   logic        r_owner_d;
   logic        r_addr_b2;
   logic [31:0] r_if_instr;
   logic [63:0] r_d_rdata;

   logic        w_idle;
   logic        w_grant_d;
   logic        w_grant_if;
   logic        w_grant;
   logic [63:0] w_sel_addr;
   logic        w_unused;

   // Grants are gated by reset so the memory never sees a strobe while the block is held in reset.
   assign w_idle     = (r_state == IDLE) & reset;
   assign w_grant_d  = w_idle & d_req;
   assign w_grant_if = w_idle & ~d_req & if_req;
   assign w_grant    = w_grant_d | w_grant_if;
   assign w_sel_addr = w_grant_d ? d_addr : if_addr;
   assign w_unused   = ^w_sel_addr[1:0];

   assign mem_en    = w_grant;
   assign mem_we    = w_grant_d & d_we;
   assign mem_addr  = w_grant ? {w_sel_addr[63:3], 3'b000} : 64'h0;
   assign mem_wdata = w_grant_d ? d_wdata : 64'h0;

   assign if_ready = (r_state == DONE) & ~r_owner_d;
   assign d_ready  = (r_state == DONE) & r_owner_d;
   assign if_instr = r_if_instr;
   assign d_rdata  = r_d_rdata;
   assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_d & d_we)
               w_next_state = DONE;
            else if (w_grant)
               w_next_state = RD_WAIT;
         end
         RD_WAIT: begin
            if (r_cnt == 3'd0)
               w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= 3'd0;
         r_owner_d  <= 1'b0;
         r_addr_b2  <= 1'b0;
         r_if_instr <= 32'h0;
         r_d_rdata  <= 64'h0;
      end else begin
         r_state <= w_next_state;
         if (w_grant) begin
            r_owner_d <= w_grant_d;
            r_addr_b2 <= w_sel_addr[2];
            r_cnt     <= 3'(RD_LAT - 1);
         end else if (r_state == RD_WAIT) begin
            if (r_cnt == 3'd0) begin
               // Each requester keeps its own result so one side's traffic never disturbs the other's hold value.
               if (r_owner_d)
                  r_d_rdata <= mem_rdata;
               else
                  r_if_instr <= r_addr_b2 ? mem_rdata[63:32] : mem_rdata[31:0];
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] r_stat_if;
   logic [31:0] r_stat_d;
   logic [31:0] r_stat_conf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_if   <= 32'h0;
         r_stat_d    <= 32'h0;
         r_stat_conf <= 32'h0;
      end else begin
         if (w_grant_if)
            r_stat_if <= r_stat_if + 32'd1;
         if (w_grant_d)
            r_stat_d <= r_stat_d + 32'd1;
         if (w_idle & if_req & d_req)
            r_stat_conf <= r_stat_conf + 32'd1;
      end
   end

   assign stat_if_grants = r_stat_if;
   assign stat_d_grants  = r_stat_d;
   assign stat_conflicts = r_stat_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written multi-cycle sequences.
// Build with MEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_mem_port_arbiter;
   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = 64'h0;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [63:0] d_addr = 64'h0;
   logic [63:0] d_wdata = 64'h0;
   logic [63:0] d_rdata;
   logic        d_ready;
   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        stall;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_grants;
   logic [31:0] stat_d_grants;
   logic [31:0] stat_conflicts;
   int          exp_if_grants = 0;
   int          exp_d_grants = 0;
   int          exp_conflicts = 0;
`endif

   int total = 0;
   int bad = 0;

   logic [31:0] exp_if_q[$];
   logic [63:0] exp_d_q[$];
   logic [63:0] last_load = 64'h0;

   mem_port_arbiter #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
`ifdef MEM_ARB_STATS_EN
      , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants),
      .stat_conflicts(stat_conflicts)
`endif
   );

   // clock and memory model
   always #5 clk = ~clk;

   logic [63:0] mem_model [logic [60:0]];
   logic [63:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (mem_en && !mem_we)
         rd_pipe[0] <= mem_model.exists(mem_addr[63:3]) ? mem_model[mem_addr[63:3]] : 64'h0;
      else
         rd_pipe[0] <= 64'hBADBADBADBADBAD0;
      for (int i = 1; i < RD_LAT; i++)
         rd_pipe[i] <= rd_pipe[i-1];
      if (mem_en && mem_we)
         mem_model[mem_addr[63:3]] = mem_wdata;
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: completions are popped and compared when ready pulses
   always @(negedge clk) begin
      if (if_ready) begin
         if (exp_if_q.size() == 0)
            check("if_ready_unexpected", 64'(if_ready), 64'h0);
         else
            check("if_instr", 64'(if_instr), 64'(exp_if_q.pop_front()));
      end
      if (d_ready) begin
         if (exp_d_q.size() == 0)
            check("d_ready_unexpected", 64'(d_ready), 64'h0);
         else
            check("d_rdata", d_rdata, exp_d_q.pop_front());
      end
   end

   // drives one request from an IDLE cycle and holds it until its ready
   task automatic do_access(input logic is_d, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp);
      int k;
      int want_lat;
      bit seen;
      @(negedge clk);
      if (!is_d) begin
         exp_if_q.push_back(exp[31:0]);
`ifdef MEM_ARB_STATS_EN
         exp_if_grants++;
`endif
      end else begin
         if (!we)
            last_load = exp;
         exp_d_q.push_back(last_load);
`ifdef MEM_ARB_STATS_EN
         exp_d_grants++;
`endif
      end
      if_req  = !is_d;
      if_addr = addr;
      d_req   = is_d;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      #1;
      check("grant_mem_en", 64'(mem_en), 64'h1);
      check("grant_mem_we", 64'(mem_we), 64'(is_d & we));
      check("grant_mem_addr", mem_addr, {addr[63:3], 3'b000});
      if (is_d && we)
         check("grant_mem_wdata", mem_wdata, wdata);
      check("grant_stall", 64'(stall), 64'h1);
      want_lat = (is_d && we) ? 1 : RD_LAT + 1;
      seen = 0;
      k = 0;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         seen = is_d ? d_ready : if_ready;
      end
      if (!seen)
         check("ready_timeout", 64'(seen), 64'h1);
      else begin
         check("ready_latency", 64'(k), 64'(want_lat));
         check("ready_stall", 64'(stall), 64'h0);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 64'h4,   64'h0,                 64'h0000_0013};
      vecs[1] = '{1'b0, 1'b0, 64'h0,   64'h0,                 64'h0050_0093};
      vecs[2] = '{1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF,         64'h0};
      vecs[3] = '{1'b1, 1'b0, 64'h100, 64'h0,                 64'hDEAD_BEEF};
      vecs[4] = '{1'b1, 1'b0, 64'h107, 64'h0,                 64'hDEAD_BEEF};
      vecs[5] = '{1'b1, 1'b1, 64'h208, 64'h0123_4567_89AB_CDEF, 64'h0};
      vecs[6] = '{1'b0, 1'b0, 64'h20C, 64'h0,                 64'h0123_4567};
      vecs[7] = '{1'b0, 1'b0, 64'h208, 64'h0,                 64'h89AB_CDEF};
      vecs[8] = '{1'b1, 1'b0, 64'h208, 64'h0,                 64'h0123_4567_89AB_CDEF};
      mem_model[61'h0] = 64'h0000_0013_0050_0093;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_mem_en", 64'(mem_en), 64'h0);
      check("rst_mem_we", 64'(mem_we), 64'h0);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_if_ready", 64'(if_ready), 64'h0);
      check("rst_d_ready", 64'(d_ready), 64'h0);
      check("rst_if_instr", 64'(if_instr), 64'h0);
      check("rst_d_rdata", d_rdata, 64'h0);
      check("rst_stall", 64'(stall), 64'h0);
      reset = 1'b1;

      for (int i = 0; i < 9; i++)
         do_access(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // simultaneous requests: data first, fetch after data's DONE
      @(negedge clk);
      exp_d_q.push_back(64'hDEAD_BEEF);
      exp_if_q.push_back(32'h0000_0013);
      last_load = 64'hDEAD_BEEF;
`ifdef MEM_ARB_STATS_EN
      exp_d_grants++;
      exp_if_grants++;
      exp_conflicts++;
`endif
      if_req = 1'b1; if_addr = 64'h4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
      #1;
      check("cont_grant_addr", mem_addr, 64'h100);
      check("cont_grant_we", 64'(mem_we), 64'h0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("cont_d_ready", 64'(d_ready), 64'(k == 3));
         check("cont_if_ready", 64'(if_ready), 64'(k == 7));
         check("cont_stall", 64'(stall), 64'(k < 7));
         if (k == 3) d_req = 1'b0;
         #1;
         check("cont_mem_en", 64'(mem_en), 64'(k == 4));
         if (k == 4) check("cont_if_addr", mem_addr, 64'h0);
         if (k == 7) if_req = 1'b0;
      end

      // requester drops d_req one cycle into a load
      @(negedge clk);
      exp_d_q.push_back(64'h0123_4567_89AB_CDEF);
      last_load = 64'h0123_4567_89AB_CDEF;
`ifdef MEM_ARB_STATS_EN
      exp_d_grants++;
`endif
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h208;
      #1;
      check("drop_mem_en", 64'(mem_en), 64'h1);
      @(negedge clk);
      d_req = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         check("drop_d_ready", 64'(d_ready), 64'(k == 3));
      end

`ifdef MEM_ARB_STATS_EN
      @(negedge clk);
      check("stat_if", 64'(stat_if_grants), 64'(exp_if_grants));
      check("stat_d", 64'(stat_d_grants), 64'(exp_d_grants));
      check("stat_conf", 64'(stat_conflicts), 64'(exp_conflicts));
`endif

      // reset during a fetch: no ready, outputs cleared, late read data ignored
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h0;
      #1;
      check("rmid_grant", 64'(mem_en), 64'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rmid_if_ready", 64'(if_ready), 64'h0);
      check("rmid_if_instr", 64'(if_instr), 64'h0);
      check("rmid_d_rdata", d_rdata, 64'h0);
      check("rmid_mem_en", 64'(mem_en), 64'h0);
      check("rmid_stall", 64'(stall), 64'h1);
      if_req = 1'b0;
      last_load = 64'h0;
`ifdef MEM_ARB_STATS_EN
      exp_if_grants = 0;
      exp_d_grants = 0;
      exp_conflicts = 0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rpost_quiet", 64'({if_ready, d_ready}), 64'h0);
      end
      do_access(1'b0, 1'b0, 64'h4, 64'h0, 64'h0000_0013);
      do_access(1'b1, 1'b1, 64'h300, 64'h55AA, 64'h0);
      do_access(1'b1, 1'b0, 64'h300, 64'h0, 64'h55AA);

`ifdef MEM_ARB_STATS_EN
      @(negedge clk);
      check("stat_if_post", 64'(stat_if_grants), 64'(exp_if_grants));
      check("stat_d_post", 64'(stat_d_grants), 64'(exp_d_grants));
      check("stat_conf_post", 64'(stat_conflicts), 64'(exp_conflicts));
`endif

      repeat (3) @(negedge clk);
      check("if_queue_drained", 64'(exp_if_q.size()), 64'h0);
      check("d_queue_drained", 64'(exp_d_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
